// File: rtl/instr_encoder.sv
// Purpose: packs 16-bit short and 32-bit long instructions into 32-bit words, padding with a NOP half when needed.
// Latency: one cycle from the accepting edge to out_word; a held long word follows its padded word directly.
// Backpressure: in_ready drops while the output register is stalled or a long word is waiting behind a padded word.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         request handshake
//   kind, alu_opcode, cond,
//   op1, op2, wren, immediate   request fields
//   flush                       emit a half-filled word padded with a NOP
//   out_valid / out_ready       output handshake
//   out_word                    encoded instruction word (upper half is the earlier instruction)
//   err                         one-cycle pulse after an illegal request is accepted
module instr_encoder #(
  parameter int WIDTH       = 32,
  parameter int REGS_CODING = 3,
  parameter int OPCODE      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             kind,
  input  logic [OPCODE-1:0]      alu_opcode,
  input  logic [3:0]             cond,
  input  logic [REGS_CODING-1:0] op1,
  input  logic [REGS_CODING-1:0] op2,
  input  logic                   wren,
  input  logic [15:0]            immediate,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_word,
  output logic                   err
);

  localparam int HW = WIDTH / 2;
  // mov r0,r0 with the never-execute condition
  localparam logic [HW-1:0] NOP_HALF = 16'h0AC0;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    HALF      = 2'd1,
    LONG_PEND = 2'd2
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [HW-1:0]    r_pending, w_nxt_pending;
  logic [WIDTH-1:0] r_long, w_nxt_long;
  logic [WIDTH-1:0] r_out_word, w_nxt_word;
  logic             r_out_valid, w_nxt_valid;
  logic             r_err, w_nxt_err;

  logic [HW-1:0]    w_short;
  logic [WIDTH-1:0] w_long;
  logic             w_is_long;
  logic             w_illegal;
  logic             w_out_free;
  logic             w_accept;

  // Request decode: encodings and legality.
  always_comb begin
    w_short   = '0;
    w_long    = '0;
    w_is_long = 1'b0;
    w_illegal = 1'b0;
    case (kind)
      3'd0: w_short = {2'b01, alu_opcode, cond, op1, op2};
      3'd1: w_short = {2'b00, 3'b000, wren, cond, op1, op2};
      3'd2: w_short = {2'b00, 4'b0010, cond, op1, op2};
      3'd3: begin
        w_is_long = 1'b1;
        w_illegal = (op1 > 3'd5);
        w_long    = {2'b10, 5'b01100 + 5'(op1), cond, 5'b00000, immediate};
      end
      3'd4: begin
        w_is_long = 1'b1;
        w_illegal = (op1 > 3'd5);
        w_long    = {2'b10, 5'b00110 + 5'(op1), cond, 5'b00000, immediate};
      end
      3'd5: begin
        w_illegal = (op1 > 3'd5);
        w_short   = {2'b00, 5'b10010 + 5'(op1), 9'b0};
      end
      3'd6: begin
        w_illegal = (cond > 4'd5);
        w_short   = {2'b00, 5'b11000 + {2'b00, cond[2:0]}, 9'b0};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // The output register can take a new word if it is empty or being drained this cycle.
  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state != LONG_PEND) && w_out_free;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_pending = r_pending;
    w_nxt_long    = r_long;
    w_nxt_word    = r_out_word;
    w_nxt_valid   = r_out_valid && !out_ready;
    w_nxt_err     = 1'b0;

    if (w_accept) begin
      if (w_illegal) begin
        // Consumed without effect beyond the error pulse.
        w_nxt_err = 1'b1;
      end else if (w_is_long) begin
        if (r_state == HALF) begin
          // A long word cannot share a word: pad the pending half and hold the long one.
          w_nxt_word  = {r_pending, NOP_HALF};
          w_nxt_valid = 1'b1;
          w_nxt_long  = w_long;
          w_nxt_state = LONG_PEND;
        end else begin
          w_nxt_word  = w_long;
          w_nxt_valid = 1'b1;
        end
      end else begin
        if (r_state == HALF) begin
          w_nxt_word  = {r_pending, w_short};
          w_nxt_valid = 1'b1;
          w_nxt_state = EMPTY;
        end else begin
          w_nxt_pending = w_short;
          w_nxt_state   = HALF;
        end
      end
    end else if (r_state == LONG_PEND) begin
      // Back-to-back: the held long word replaces the padded word as it drains.
      if (r_out_valid && out_ready) begin
        w_nxt_word  = r_long;
        w_nxt_valid = 1'b1;
        w_nxt_state = EMPTY;
      end
    end else if ((r_state == HALF) && flush && w_out_free) begin
      w_nxt_word  = {r_pending, NOP_HALF};
      w_nxt_valid = 1'b1;
      w_nxt_state = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_pending   <= '0;
      r_long      <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_pending   <= w_nxt_pending;
      r_long      <= w_nxt_long;
      r_out_word  <= w_nxt_word;
      r_out_valid <= w_nxt_valid;
      r_err       <= w_nxt_err;
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose: directed, table-driven check of instr_encoder encodings, pairing, padding, flush, errors and reset.
// Latency: expects each word one cycle after its accepting or flushing edge.
// Backpressure: exercises output stalls with out_ready held low.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  kind;
  logic [3:0]  alu_opcode;
  logic [3:0]  cond;
  logic [2:0]  op1;
  logic [2:0]  op2;
  logic        wren;
  logic [15:0] immediate;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        err;

  instr_encoder #(.WIDTH(32), .REGS_CODING(3), .OPCODE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .kind       (kind),
    .alu_opcode (alu_opcode),
    .cond       (cond),
    .op1        (op1),
    .op2        (op2),
    .wren       (wren),
    .immediate  (immediate),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  opc;
    logic [3:0]  cond;
    logic [2:0]  op1;
    logic [2:0]  op2;
    logic        wren;
    logic [15:0] imm;
    logic        has_word;
    logic [31:0] word;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] q_words[$];
  int          err_seen = 0;

  // Observe handshaken words and error pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) q_words.push_back(out_word);
      if (err) err_seen++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [2:0] k, input logic [3:0] opc, input logic [3:0] c,
                      input logic [2:0] a, input logic [2:0] b, input logic w,
                      input logic [15:0] im, input logic hw, input logic [31:0] wd,
                      input logic e);
    vec_t v;
    v.kind = k; v.opc = opc; v.cond = c; v.op1 = a; v.op2 = b; v.wren = w;
    v.imm = im; v.has_word = hw; v.word = wd; v.exp_err = e;
    vecs.push_back(v);
  endtask

  // Present one request and hold it until accepted; returns at posedge+1 after acceptance.
  task automatic send_req(input logic [2:0] k, input logic [3:0] opc, input logic [3:0] c,
                          input logic [2:0] a, input logic [2:0] b, input logic w,
                          input logic [15:0] im);
    int  n;
    bit  done;
    kind = k; alu_opcode = opc; cond = c; op1 = a; op2 = b; wren = w; immediate = im;
    in_valid = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        n++;
        if (n > 50) begin
          n_vec++;
          n_bad++;
          $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; kind = '0; alu_opcode = '0; cond = '0;
    op1 = '0; op2 = '0; wren = 1'b0; immediate = '0; flush = 1'b0; out_ready = 1'b1;

    // kind opc  cond  op1  op2  wren imm        has  word          err
    addv(3'd0, 4'h1, 4'hA, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 32'h46930AC0, 1'b0);
    addv(3'd0, 4'hF, 4'h0, 3'd7, 3'd7, 1'b0, 16'h0000, 1'b1, 32'h7C3F0AC0, 1'b0);
    addv(3'd1, 4'h0, 4'hA, 3'd1, 3'd4, 1'b1, 16'h0000, 1'b1, 32'h068C0AC0, 1'b0);
    addv(3'd1, 4'h0, 4'h3, 3'd5, 3'd2, 1'b0, 16'h0000, 1'b1, 32'h00EA0AC0, 1'b0);
    addv(3'd2, 4'h0, 4'hE, 3'd3, 3'd6, 1'b0, 16'h0000, 1'b1, 32'h0B9E0AC0, 1'b0);
    addv(3'd5, 4'h0, 4'h0, 3'd5, 3'd0, 1'b0, 16'h0000, 1'b1, 32'h2E000AC0, 1'b0);
    addv(3'd5, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 32'h24000AC0, 1'b0);
    addv(3'd6, 4'h0, 4'h1, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 32'h32000AC0, 1'b0);
    addv(3'd6, 4'h0, 4'h5, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 32'h3A000AC0, 1'b0);
    addv(3'd6, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 32'h30000AC0, 1'b0);
    addv(3'd3, 4'h0, 4'hA, 3'd2, 3'd0, 1'b0, 16'h1234, 1'b1, 32'h9D401234, 1'b0);
    addv(3'd4, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 16'hFFFF, 1'b1, 32'h8C00FFFF, 1'b0);
    addv(3'd4, 4'h0, 4'hF, 3'd5, 3'd0, 1'b0, 16'h0001, 1'b1, 32'h97E00001, 1'b0);
    addv(3'd3, 4'h0, 4'h1, 3'd5, 3'd0, 1'b0, 16'hABCD, 1'b1, 32'hA220ABCD, 1'b0);
    addv(3'd7, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 32'h00000000, 1'b1);
    addv(3'd4, 4'h0, 4'h0, 3'd6, 3'd0, 1'b0, 16'h5555, 1'b0, 32'h00000000, 1'b1);
    addv(3'd3, 4'h0, 4'h0, 3'd7, 3'd0, 1'b0, 16'h5555, 1'b0, 32'h00000000, 1'b1);
    addv(3'd5, 4'h0, 4'h0, 3'd6, 3'd0, 1'b0, 16'h0000, 1'b0, 32'h00000000, 1'b1);
    addv(3'd6, 4'h0, 4'h6, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 32'h00000000, 1'b1);
    addv(3'd6, 4'h0, 4'hF, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 32'h00000000, 1'b1);

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table: single request then flush, from EMPTY with the consumer always ready.
    for (int i = 0; i < vecs.size(); i++) begin
      q_words.delete();
      err_seen = 0;
      send_req(vecs[i].kind, vecs[i].opc, vecs[i].cond, vecs[i].op1, vecs[i].op2,
               vecs[i].wren, vecs[i].imm);
      pulse_flush();
      idle(4);
      chk($sformatf("vec%0d_count", i), q_words.size(), {31'b0, vecs[i].has_word});
      if (vecs[i].has_word && q_words.size() > 0)
        chk($sformatf("vec%0d_word", i), q_words[0], vecs[i].word);
      chk($sformatf("vec%0d_err", i), err_seen, {31'b0, vecs[i].exp_err});
    end

    // ALU then store pair into one word, one cycle after the second accept.
    q_words.delete();
    send_req(3'd0, 4'h1, 4'hA, 3'd2, 3'd3, 1'b0, 16'h0);
    send_req(3'd1, 4'h0, 4'hA, 3'd1, 3'd4, 1'b1, 16'h0);
    @(negedge clk);
    chk("pair_valid", {31'b0, out_valid}, 32'd1);
    chk("pair_word", out_word, 32'h4693068C);
    idle(3);
    chk("pair_count", q_words.size(), 32'd1);

    // Flush coinciding with an accepted request is ignored: no padding word.
    q_words.delete();
    send_req(3'd0, 4'h1, 4'hA, 3'd2, 3'd3, 1'b0, 16'h0);
    flush = 1'b1;
    send_req(3'd1, 4'h0, 4'hA, 3'd1, 3'd4, 1'b1, 16'h0);
    flush = 1'b0;
    idle(4);
    chk("flushacc_count", q_words.size(), 32'd1);
    if (q_words.size() > 0) chk("flushacc_word", q_words[0], 32'h4693068C);

    // ALU then movl under a stalled consumer: padded word, then held long word.
    q_words.delete();
    send_req(3'd0, 4'h1, 4'hA, 3'd2, 3'd3, 1'b0, 16'h0);
    out_ready = 1'b0;
    send_req(3'd3, 4'h0, 4'hA, 3'd2, 3'd0, 1'b0, 16'h1234);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_word", c), out_word, 32'h46930AC0);
      chk($sformatf("stall%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("long_pend_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("long_follow_valid", {31'b0, out_valid}, 32'd1);
    chk("long_follow_word", out_word, 32'h9D401234);
    idle(3);
    chk("long_pair_count", q_words.size(), 32'd2);

    // Illegal request in HALF: one-cycle err, no word, pending half kept.
    q_words.delete();
    send_req(3'd0, 4'h1, 4'hA, 3'd2, 3'd3, 1'b0, 16'h0);
    send_req(3'd4, 4'h0, 4'h0, 3'd6, 3'd0, 1'b0, 16'h0);
    @(negedge clk);
    chk("illegal_err", {31'b0, err}, 32'd1);
    chk("illegal_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("illegal_err_drop", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    pulse_flush();
    idle(3);
    chk("illegal_keep_count", q_words.size(), 32'd1);
    if (q_words.size() > 0) chk("illegal_keep_word", q_words[0], 32'h46930AC0);

    // Reset in HALF discards the pending half; a later flush emits nothing.
    q_words.delete();
    send_req(3'd0, 4'h1, 4'hA, 3'd2, 3'd3, 1'b0, 16'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    pulse_flush();
    idle(4);
    chk("midrst_flush_count", q_words.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
